multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Multi-cycle control FSM for the 32-bit MIPS core. It sequences a shared-memory datapath with one ALU, IR, PC, register file and single instruction/data memory, one micro-step per clock. It supports LW, SW, BEQ and R-type ADD/SUB/AND/OR, with optional J. It replaces the single-cycle decoder and keeps the same `alu_op` encoding, so the ALU is unchanged. It stalls on a memory ready handshake.

## Interface
Parameters: none.

Ports:
- `clk` input 1: the only clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `opcode` input 6: IR[31:26]; stable from the cycle after FETCH completes.
- `func` input 6: IR[5:0].
- `mem_ready` input 1: memory access completes this cycle.
- `pc_write` output 1: unconditional PC load.
- `pc_write_cond` output 1: PC load if ALU zero.
- `i_or_d` output 1: memory address is 0 = PC, 1 = ALUOut.
- `mem_read` output 1: memory read request.
- `mem_write` output 1: memory write request.
- `ir_write` output 1: IR load.
- `reg_dst` output 1: write register is 0 = rt, 1 = rd.
- `mem_to_reg` output 1: write data is 0 = ALUOut, 1 = MDR.
- `reg_write` output 1: register file write.
- `alu_src_a` output 1: ALU A is 0 = PC, 1 = A register.
- `alu_src_b` output 2: ALU B is 00 = B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- `alu_op` output 2: 00 AND, 01 OR, 10 ADD, 11 SUB.
- `pc_source` output 2: 00 ALU result, 01 ALUOut, 10 jump target.
- `instr_done` output 1: one-cycle pulse on the last cycle of each instruction.
- `illegal` output 1: one-cycle pulse in DECODE for an unsupported opcode or func.

## Operation
- The state register is reset asynchronously to FETCH.
- While `rst_n`=0, all outputs are 0.
- Outputs are combinational functions of the state, plus `opcode`/`func`/`mem_ready` where stated below. Any output not listed for a state is 0.
- FETCH: `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=10, `pc_source`=00.
  - `ir_write` and `pc_write` are 1 only when `mem_ready`=1.
  - Stay in FETCH until `mem_ready`=1, then go to DECODE.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=10 (branch target into ALUOut). Next state:
  - LW or SW → MEM_ADDR
  - R-type with legal func → EXECUTE
  - BEQ → BRANCH
  - J → JUMP (only when `CTRL_JUMP_EN` is defined)
  - anything else → FETCH, with `illegal`=1 and `instr_done`=1
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=10. Go to MEM_READ for LW, MEM_WRITE for SW.
- MEM_READ: `mem_read`=1, `i_or_d`=1. Wait on `mem_ready`, then go to MEM_WB.
- MEM_WRITE: `mem_write`=1, `i_or_d`=1. Wait on `mem_ready`; on the cycle `mem_ready`=1, pulse `instr_done` and go to FETCH.
- MEM_WB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0, `instr_done`=1. Go to FETCH.
- EXECUTE: `alu_src_a`=1, `alu_src_b`=00, `alu_op` from func (ADD 10, SUB 11, AND 00, OR 01). Go to ALU_WB.
- ALU_WB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0, `instr_done`=1. Go to FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=11, `pc_write_cond`=1, `pc_source`=01, `instr_done`=1. Go to FETCH.
- JUMP: `pc_write`=1, `pc_source`=10, `instr_done`=1. Go to FETCH.
- `mem_read` and `mem_write` are never asserted together. `mem_read`/`mem_write` stay asserted for the whole stall.

## Timing
- Latency with `mem_ready` held at 1:
  - LW: 5 cycles
  - SW and R-type: 4 cycles
  - BEQ and J: 3 cycles
  - illegal instruction: 2 cycles
- Each cycle of `mem_ready`=0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- `mem_ready` is ignored in all other states.
- Reset asserted mid-instruction: outputs go to 0 immediately and no partial write is issued. After release, the first edge samples FETCH.
- The first FETCH after reset may complete on the first edge after release.

## Configuration
- `CTRL_JUMP_EN` defined: opcode 6'b000010 is decoded and goes DECODE → JUMP.
  - `pc_source`=10 is then reachable.
- `CTRL_JUMP_EN` not defined: the JUMP state does not exist, and opcode 000010 is treated as illegal.
  - `pc_source` never leaves {00, 01}.

## Structure
- Package `mips_ctrl_pkg` holds:
  - opcode constants (LW 100011, SW 101011, BEQ 000100, RTYPE 000000, J 000010)
  - func constants (ADD 100000, SUB 100010, AND 100100, OR 100101)
  - `alu_op` encodings
  - the state enum
- Sub-module `alu_op_decode` maps `func` to `alu_op` plus a legal flag. It is shared with EXECUTE and DECODE.

## Test plan
- Reset with `rst_n`=0 mid-MEM_WRITE → `mem_write` drops to 0 the same cycle; after release, FETCH asserts `mem_read`=1, `i_or_d`=0.
- LW with `mem_ready`=1 throughout → `instr_done` pulses in cycle 5, and `reg_write`=1 with `mem_to_reg`=1 in that cycle.
- SUB (func 100010), then OR (func 100101) → in EXECUTE `alu_op`=11 and then 01; `reg_dst`=1 in ALU_WB; 4 cycles each.
- BEQ → cycle 3 shows `pc_write_cond`=1, `pc_source`=01, `alu_op`=11.
- LW with `mem_ready` low for 2 cycles in FETCH and 3 in MEM_READ → total 10 cycles; `ir_write` high for exactly one cycle.
- Opcode 000010 → with the macro: 3 cycles, `pc_source`=10. Without the macro: `illegal` pulses in cycle 2 and the next instruction is fetched.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared constants and state type for the multi-cycle MIPS controller.
// CTRL_JUMP_EN adds the JUMP state and J decode.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  localparam logic [1:0] PCS_ALU  = 2'b00;
  localparam logic [1:0] PCS_OUT  = 2'b01;
  localparam logic [1:0] PCS_JUMP = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_READ,
    S_MEM_WRITE,
    S_MEM_WB,
    S_EXECUTE,
    S_ALU_WB,
    S_BRANCH
`ifdef CTRL_JUMP_EN
    , S_JUMP
`endif
  } state_e;

  function automatic logic is_mem_op(
    input logic [5:0] op
  );
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// R-type func field to ALU operation, with a legality flag.
// Used by both DECODE (legality) and EXECUTE (operation).
module alu_op_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] func_i,
  output logic [1:0] alu_op_o,
  output logic       legal_o
);

  // Map the supported funcs; anything else is flagged illegal.
  always_comb begin
    alu_op_o = ALU_ADD;
    legal_o  = 1'b1;
    unique case (1'b1)
      (func_i == FN_ADD): alu_op_o = ALU_ADD;
      (func_i == FN_SUB): alu_op_o = ALU_SUB;
      (func_i == FN_AND): alu_op_o = ALU_AND;
      (func_i == FN_OR):  alu_op_o = ALU_OR;
      default: begin
        alu_op_o = ALU_ADD;
        legal_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the shared-memory MIPS datapath.
// Define CTRL_JUMP_EN to decode J (opcode 000010) into a JUMP state.
module multicycle_controller
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal
);

  state_e     state_q;
  state_e     state_d;
  logic [1:0] fn_op;
  logic       fn_ok;
  logic       is_lw;
  logic       is_sw;
  logic       is_beq;
  logic       is_r;
  logic       is_j;
  logic       dec_ok;

  alu_op_decode u_fn (
    .func_i   (func),
    .alu_op_o (fn_op),
    .legal_o  (fn_ok)
  );

  // Opcode classification; J only counts when jump support is built in.
  always_comb begin
    is_lw  = (opcode == OP_LW);
    is_sw  = (opcode == OP_SW);
    is_beq = (opcode == OP_BEQ);
    is_r   = (opcode == OP_RTYPE);
`ifdef CTRL_JUMP_EN
    is_j   = (opcode == OP_J);
`else
    is_j   = 1'b0;
`endif
    dec_ok = is_lw | is_sw | is_beq | is_j
           | (is_r & fn_ok);
  end

  // State register, asynchronously forced to FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state sequencing; memory states hold until mem_ready.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        unique case (1'b1)
          is_mem_op(opcode): state_d = S_MEM_ADDR;
          (is_r & fn_ok):    state_d = S_EXECUTE;
          is_beq:            state_d = S_BRANCH;
`ifdef CTRL_JUMP_EN
          is_j:              state_d = S_JUMP;
`endif
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        if (is_lw)      state_d = S_MEM_READ;
        else if (is_sw) state_d = S_MEM_WRITE;
        else            state_d = S_FETCH;
      end
      S_MEM_READ: begin
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WRITE: begin
        if (mem_ready) state_d = S_FETCH;
      end
      S_MEM_WB:  state_d = S_FETCH;
      S_EXECUTE: state_d = S_ALU_WB;
      S_ALU_WB:  state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
`ifdef CTRL_JUMP_EN
      S_JUMP:    state_d = S_FETCH;
`endif
      default:   state_d = S_FETCH;
    endcase
  end

  // Datapath controls per state; all low while reset is held.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_AND;
    pc_source     = PCS_ALU;
    instr_done    = 1'b0;
    illegal       = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_4;
          alu_op    = ALU_ADD;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b  = SRCB_IMM2;
          alu_op     = ALU_ADD;
          illegal    = ~dec_ok;
          instr_done = ~dec_ok;
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALU_ADD;
        end
        S_MEM_READ: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_write  = 1'b1;
          i_or_d     = 1'b1;
          instr_done = mem_ready;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        S_EXECUTE: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_B;
          alu_op    = fn_op;
        end
        S_ALU_WB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_src_b     = SRCB_B;
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PCS_OUT;
          instr_done    = 1'b1;
        end
`ifdef CTRL_JUMP_EN
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_source  = PCS_JUMP;
          instr_done = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: vector table plus scoreboard,
// with hand sequences for reset and stall corners.
module tb_multicycle_controller;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       instr_done;
  logic       illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .func          (func),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .instr_done    (instr_done),
    .illegal       (illegal)
  );

  // {reg_write, mem_to_reg, reg_dst, mem_write,
  //  pc_write_cond, pc_write, pc_source, alu_op, illegal}
  localparam logic [10:0] L_LW  = 11'b110_000_00_00_0;
  localparam logic [10:0] L_SW  = 11'b000_100_00_00_0;
  localparam logic [10:0] L_R   = 11'b101_000_00_00_0;
  localparam logic [10:0] L_BEQ = 11'b000_010_01_11_0;
  localparam logic [10:0] L_J   = 11'b000_001_10_00_0;
  localparam logic [10:0] L_ILL = 11'b000_000_00_10_1;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] fn;
    int         fs;
    int         ms;
    int         cyc;
    logic [1:0] alu3;
    logic [10:0] last;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [1:0]  alu3;
    logic [10:0] last;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];

  function automatic logic [10:0] last_vec();
    return {reg_write, mem_to_reg, reg_dst, mem_write,
            pc_write_cond, pc_write, pc_source,
            alu_op, illegal};
  endfunction

  function automatic logic [19:0] all_outs();
    return {pc_write, pc_write_cond, i_or_d, mem_read,
            mem_write, ir_write, reg_dst, mem_to_reg,
            reg_write, alu_src_a, alu_src_b, alu_op,
            pc_source, instr_done, illegal};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    exp_t        e;
    exp_t        g;
    int          c;
    int          irw;
    int          fs;
    int          ms;
    logic        bad;
    logic        done;
    logic [1:0]  a3;
    logic [10:0] lv;
    e.cyc  = v.cyc;
    e.alu3 = v.alu3;
    e.last = v.last;
    sb.push_back(e);
    fs = v.fs;
    ms = v.ms;
    c = 0;
    irw = 0;
    bad = 1'b0;
    done = 1'b0;
    a3 = 2'b00;
    lv = '0;
    while (!done && c < 40) begin
      @(negedge clk);
      if (c == 0) begin
        opcode = v.op;
        func   = v.fn;
      end
      if (mem_read && !i_or_d) begin
        if (fs > 0) begin
          mem_ready = 1'b0;
          fs--;
        end else mem_ready = 1'b1;
      end else if ((mem_read || mem_write) && i_or_d) begin
        if (ms > 0) begin
          mem_ready = 1'b0;
          ms--;
        end else mem_ready = 1'b1;
      end else begin
        mem_ready = 1'($urandom_range(1));
      end
      #1;
      c++;
      if (ir_write) irw++;
      if (mem_read && mem_write) bad = 1'b1;
`ifndef CTRL_JUMP_EN
      if (pc_source == PCS_JUMP) bad = 1'b1;
`endif
      if (c == v.fs + 3) a3 = alu_op;
      if (instr_done) begin
        done = 1'b1;
        lv = last_vec();
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no instr_done in %0d cycles",
               v.name, c);
      void'(sb.pop_back());
    end else begin
      g = sb.pop_front();
      chk({v.name, "_cycles"}, c, g.cyc);
      chk({v.name, "_last"}, 32'(lv), 32'(g.last));
      chk({v.name, "_alu3"}, 32'(a3), 32'(g.alu3));
      chk({v.name, "_ir_write"}, irw, 1);
      chk({v.name, "_invariant"}, 32'(bad), 0);
    end
  endtask

  initial begin
    int   n;
    logic hit;
    vec_t lw_after;

    vt.push_back('{"lw", OP_LW, 6'd0, 0, 0, 5, ALU_ADD, L_LW});
    vt.push_back('{"sw", OP_SW, 6'd0, 0, 0, 4, ALU_ADD, L_SW});
    vt.push_back('{"sub", OP_RTYPE, FN_SUB, 0, 0, 4, ALU_SUB, L_R});
    vt.push_back('{"or", OP_RTYPE, FN_OR, 0, 0, 4, ALU_OR, L_R});
    vt.push_back('{"add", OP_RTYPE, FN_ADD, 0, 0, 4, ALU_ADD, L_R});
    vt.push_back('{"and", OP_RTYPE, FN_AND, 0, 0, 4, ALU_AND, L_R});
    vt.push_back('{"beq", OP_BEQ, 6'd0, 0, 0, 3, ALU_SUB, L_BEQ});
    vt.push_back('{"lw_stall", OP_LW, 6'd0, 2, 3, 10, ALU_ADD, L_LW});
    vt.push_back('{"sw_stall", OP_SW, 6'd0, 1, 2, 7, ALU_ADD, L_SW});
`ifdef CTRL_JUMP_EN
    vt.push_back('{"j", OP_J, 6'd0, 0, 0, 3, ALU_AND, L_J});
`else
    vt.push_back('{"j_ill", OP_J, 6'd0, 0, 0, 2, ALU_AND, L_ILL});
`endif
    vt.push_back('{"bad_fn", OP_RTYPE, 6'd0, 0, 0, 2, ALU_AND, L_ILL});
    vt.push_back('{"bad_op", 6'h3f, FN_ADD, 0, 0, 2, ALU_AND, L_ILL});
    vt.push_back('{"sub_fs", OP_RTYPE, FN_SUB, 1, 0, 5, ALU_SUB, L_R});
    vt.push_back('{"beq_fs", OP_BEQ, 6'd0, 3, 0, 6, ALU_SUB, L_BEQ});
    vt.push_back('{"lw_next", OP_LW, 6'd0, 0, 1, 6, ALU_ADD, L_LW});

    rst_n = 1'b0;
    mem_ready = 1'b1;
    opcode = 6'd0;
    func = 6'd0;
    #2;
    chk("reset_outs", 32'(all_outs()), 0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_outs_held", 32'(all_outs()), 0);
    mem_ready = 1'b0;
    rst_n = 1'b1;

    foreach (vt[i]) run(vt[i]);

    n = 0;
    hit = 1'b0;
    while (!hit && n < 20) begin
      @(negedge clk);
      opcode = OP_SW;
      func = 6'd0;
      mem_ready = !mem_write;
      #1;
      n++;
      hit = mem_write;
    end
    chk("sw_write_stall", 32'(hit), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_write", 32'(all_outs()), 0);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_fetch",
        32'({mem_read, i_or_d, mem_write}), 32'b100);

    lw_after = '{"lw_after_rst", OP_LW, 6'd0, 0, 0,
                 5, ALU_ADD, L_LW};
    run(lw_after);

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
